drygascon_bdo_serializer: RTL and testbench

- Output-side companion to the DryGASCON256 core's input loader.
- Accepts one 256-bit result block (ciphertext, plaintext, tag or digest) from the core datapath per handshake. Streams it MSW-first as CCW-bit words to the LWC post-processor over bdo/bdo_valid/bdo_ready.
- Forwards the decrypt tag-check verdict over msg_auth/msg_auth_valid/msg_auth_ready.
- Owns all bdo_* and msg_auth* ports of the CryptoCore top.

---
 rtl/drygascon_pkg.sv | 24 ++
 rtl/drygascon_lane_mask.sv | 20 ++
 rtl/drygascon_bdo_serializer.sv | 99 +++++++++
 tb/tb_drygascon_bdo_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/drygascon_pkg.sv
// drygascon_pkg: shared constants, LWC segment codes and serializer states
package drygascon_pkg;
    localparam int CCW       = 32;
    localparam int CCWdiv8   = CCW / 8;
    localparam int BLK_BITS  = 256;
    localparam int BLK_WORDS = BLK_BITS / CCW;
    localparam int BLK_BYTES = BLK_BITS / 8;

    localparam int DRYSPONGE_BLOCKSIZE_BITS  = BLK_BITS;
    localparam int DRYSPONGE_BLOCKSIZE_BYTES = BLK_BYTES;
    localparam int DRYSPONGE_BLOCKSIZE_WORDS = BLK_WORDS;

    localparam logic [3:0] HDR_NPUB       = 4'b1101;
    localparam logic [3:0] HDR_PT         = 4'b0100;
    localparam logic [3:0] HDR_CT         = 4'b0101;
    localparam logic [3:0] HDR_TAG        = 4'b1000;
    localparam logic [3:0] HDR_HASH_VALUE = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_AUTH = 2'd2
    } ser_state_t;
endpackage

// File: rtl/drygascon_lane_mask.sv
// drygascon_lane_mask: remaining byte count to byte-lane valid mask and data zeroing mask
module drygascon_lane_mask
    import drygascon_pkg::*;
(
    input  logic [5:0]         rem_bytes,
    output logic [CCWdiv8-1:0] valid_bytes,
    output logic [CCW-1:0]     zero_mask
);
    // Lanes fill from the MSB because the first byte of a word sits in its top bits
    always_comb begin
        valid_bytes = rem_bytes >= 6'd4 ? 4'b1111 :
                      rem_bytes == 6'd3 ? 4'b1110 :
                      rem_bytes == 6'd2 ? 4'b1100 :
                      rem_bytes == 6'd1 ? 4'b1000 : 4'b0000;
    end

    for (genvar i = 0; i < CCWdiv8; i++) begin : g_lane
        assign zero_mask[i*8 +: 8] = {8{valid_bytes[i]}};
    end
endmodule

// File: rtl/drygascon_bdo_serializer.sv
// drygascon_bdo_serializer: streams 256-bit core result blocks as 32-bit bdo words and forwards tag verdicts
module drygascon_bdo_serializer
    import drygascon_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [BLK_BITS-1:0] blk_data,
    input  logic [5:0]          blk_bytes,
    input  logic [3:0]          blk_type,
    input  logic                blk_last,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic                auth_ok,
    input  logic                auth_valid,
    output logic                auth_ready,
    output logic [CCW-1:0]      bdo,
    output logic                bdo_valid,
    input  logic                bdo_ready,
    output logic [3:0]          bdo_type,
    output logic [CCWdiv8-1:0]  bdo_valid_bytes,
    output logic                end_of_block,
    output logic                msg_auth,
    output logic                msg_auth_valid,
    input  logic                msg_auth_ready
);
    ser_state_t          state, state_nx;
    logic [BLK_BITS-1:0] sr;
    logic [5:0]          rem;
    logic [5:0]          bytes_sat;
    logic [3:0]          typ;
    logic                last, verdict;
    logic [CCWdiv8-1:0]  lanes;
    logic [CCW-1:0]      zmask;
    logic                blk_fire, auth_fire, bdo_fire, final_word;

    drygascon_lane_mask u_lane_mask (
        .rem_bytes   (rem),
        .valid_bytes (lanes),
        .zero_mask   (zmask)
    );

    assign bytes_sat  = blk_bytes > 6'd32 ? 6'd32 : blk_bytes;
    assign blk_ready  = state == S_IDLE;
    assign auth_ready = state == S_IDLE && !blk_valid;
    assign blk_fire   = blk_ready && blk_valid;
    assign auth_fire  = auth_ready && auth_valid;
    assign final_word = rem <= 6'd4;
    assign bdo_fire   = bdo_valid && bdo_ready;

    // All outputs decode registered state only, so ready inputs never reach them combinationally
    always_comb begin
        bdo_valid       = state == S_SEND;
        bdo             = bdo_valid ? sr[BLK_BITS-1 -: CCW] & zmask : '0;
        bdo_valid_bytes = bdo_valid ? lanes : '0;
        bdo_type        = bdo_valid ? typ : 4'b0;
        end_of_block    = bdo_valid && last && final_word;
        msg_auth_valid  = state == S_AUTH;
        msg_auth        = msg_auth_valid && verdict;
    end

    // Block offers win over verdicts; empty blocks are swallowed without leaving idle
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  state_nx = blk_fire ? (bytes_sat != 6'd0 ? S_SEND : S_IDLE) :
                                auth_fire ? S_AUTH : S_IDLE;
            S_SEND:  state_nx = bdo_fire && final_word ? S_IDLE : S_SEND;
            S_AUTH:  state_nx = msg_auth_ready ? S_IDLE : S_AUTH;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Block capture, word shifting and verdict latch
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            rem     <= '0;
            typ     <= '0;
            last    <= 1'b0;
            verdict <= 1'b0;
        end else if (blk_fire) begin
            sr   <= blk_data;
            rem  <= bytes_sat;
            typ  <= blk_type;
            last <= blk_last;
        end else if (auth_fire) begin
            verdict <= auth_ok;
        end else if (bdo_fire) begin
            sr  <= sr << CCW;
            rem <= final_word ? 6'd0 : rem - 6'd4;
        end
    end
endmodule

// File: tb/tb_drygascon_bdo_serializer.sv
// tb_drygascon_bdo_serializer: scoreboard bench with a byte-level reference model
module tb_drygascon_bdo_serializer;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] blk_data;
    logic [5:0]   blk_bytes;
    logic [3:0]   blk_type;
    logic         blk_last, blk_valid, blk_ready;
    logic         auth_ok, auth_valid, auth_ready;
    logic [31:0]  bdo;
    logic         bdo_valid, bdo_ready;
    logic [3:0]   bdo_type, bdo_valid_bytes;
    logic         end_of_block, msg_auth, msg_auth_valid, msg_auth_ready;

    typedef struct {
        bit          kind;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [3:0]  typ;
        bit          eob;
        bit          fin;
    } exp_t;

    exp_t exp_q[$];
    bit   pat_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   rnd_rdy = 1'b0;
    int   mar_hold = 0;

    drygascon_bdo_serializer dut (
        .clk(clk), .rst(rst),
        .blk_data(blk_data), .blk_bytes(blk_bytes), .blk_type(blk_type), .blk_last(blk_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready),
        .auth_ok(auth_ok), .auth_valid(auth_valid), .auth_ready(auth_ready),
        .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready), .bdo_type(bdo_type),
        .bdo_valid_bytes(bdo_valid_bytes), .end_of_block(end_of_block),
        .msg_auth(msg_auth), .msg_auth_valid(msg_auth_valid), .msg_auth_ready(msg_auth_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: split the first min(n,32) bytes into 4-byte words, zero unused lanes
    function automatic void push_block(input logic [255:0] d, input logic [5:0] n,
                                       input logic [3:0] t, input bit l);
        int nb = n > 32 ? 32 : int'(n);
        int words = (nb + 3) / 4;
        for (int w = 0; w < words; w++) begin
            exp_t e;
            int lanes = nb - 4 * w >= 4 ? 4 : nb - 4 * w;
            e.kind = 1'b0; e.data = '0; e.mask = '0; e.typ = t;
            for (int j = 0; j < lanes; j++) begin
                e.data[31 - 8*j -: 8] = d[255 - 8*(4*w + j) -: 8];
                e.mask[3 - j] = 1'b1;
            end
            e.eob = l && (w == words - 1);
            e.fin = (w == words - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_auth(input bit ok);
        exp_t e;
        e.kind = 1'b1; e.data = {31'b0, ok}; e.mask = '0; e.typ = '0; e.eob = 1'b0; e.fin = 1'b1;
        exp_q.push_back(e);
    endfunction

    task automatic send_block(input logic [255:0] d, input logic [5:0] n,
                              input logic [3:0] t, input bit l);
        int k = 0;
        blk_data = d; blk_bytes = n; blk_type = t; blk_last = l; blk_valid = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!blk_ready && k < 1000);
        if (!blk_ready) check("blk_accept_timeout", 0, 1);
        else push_block(d, n, t, l);
        @(posedge clk); #1;
        blk_valid = 1'b0;
    endtask

    task automatic send_auth(input bit ok);
        int k = 0;
        auth_ok = ok; auth_valid = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!auth_ready && k < 1000);
        if (!auth_ready) check("auth_accept_timeout", 0, 1);
        else push_auth(ok);
        @(posedge clk); #1;
        auth_valid = 1'b0;
    endtask

    function automatic logic [255:0] rnd_blk();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Sink handshake drivers: scripted stall patterns, verdict hold, or random back-pressure
    initial begin
        bdo_ready = 1'b1;
        msg_auth_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bdo_valid && pat_q.size() > 0) bdo_ready = pat_q.pop_front();
            else bdo_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (msg_auth_valid && mar_hold > 0) begin
                msg_auth_ready = 1'b0;
                mar_hold--;
            end else msg_auth_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every completed handshake and checks hold/bubble rules
    initial begin
        exp_t e;
        logic [31:0] pb;
        logic [3:0]  pm, pt;
        logic        pe, pv, pr, pav, pa, par, post_fin, post_auth;
        pv = 0; pr = 0; pav = 0; par = 0; post_fin = 0; post_auth = 0;
        pb = '0; pm = '0; pt = '0; pe = 0; pa = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0; pav = 0; post_fin = 0; post_auth = 0;
                continue;
            end
            if (bdo_valid || msg_auth_valid) check("valid_exclusive", bdo_valid & msg_auth_valid, 0);
            if (post_fin) check("bubble_after_block", bdo_valid, 0);
            if (post_auth) check("auth_drop", msg_auth_valid, 0);
            if (pv && !pr)
                check("stall_hold", {bdo_valid, bdo, bdo_valid_bytes, bdo_type, end_of_block},
                      {1'b1, pb, pm, pt, pe});
            if (pav && !par) check("auth_hold", {msg_auth_valid, msg_auth}, {1'b1, pa});
            post_fin = 0; post_auth = 0;
            if (bdo_valid && bdo_ready) begin
                check("bdo_expected", exp_q.size() != 0 && !exp_q[0].kind, 1);
                if (exp_q.size() != 0 && !exp_q[0].kind) begin
                    e = exp_q.pop_front();
                    check("bdo_word", {bdo, bdo_valid_bytes, bdo_type, end_of_block},
                          {e.data, e.mask, e.typ, e.eob});
                    post_fin = e.fin;
                end
            end
            if (msg_auth_valid && msg_auth_ready) begin
                check("auth_expected", exp_q.size() != 0 && exp_q[0].kind, 1);
                if (exp_q.size() != 0 && exp_q[0].kind) begin
                    e = exp_q.pop_front();
                    check("msg_auth", msg_auth, e.data[0]);
                    post_auth = 1;
                end
            end
            pb = bdo; pm = bdo_valid_bytes; pt = bdo_type; pe = end_of_block;
            pv = bdo_valid; pr = bdo_ready; pav = msg_auth_valid; pa = msg_auth; par = msg_auth_ready;
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [255:0] d;
        int k;
        rst = 1'b1; blk_data = '0; blk_bytes = '0; blk_type = '0; blk_last = 1'b0; blk_valid = 1'b0;
        auth_ok = 1'b0; auth_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {bdo_valid, bdo, bdo_type, bdo_valid_bytes, end_of_block, msg_auth, msg_auth_valid}, 0);
        check("reset_ready", {blk_ready, auth_ready}, 2'b11);
        @(posedge clk); #1;

        // Full 32-byte block, ready tied high: 8 back-to-back words, ready returns after them
        for (int i = 0; i < 32; i++) d[255 - 8*i -: 8] = 8'(i);
        send_block(d, 6'd32, 4'b0101, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("full_blk_streaming", {blk_ready, bdo_valid}, 2'b01);
        end
        @(negedge clk);
        check("full_blk_ready_back", {blk_ready, bdo_valid}, 2'b10);
        @(posedge clk); #1;

        // Short 5-byte block with junk beyond the valid bytes
        d = rnd_blk();
        d[255 -: 40] = 40'hAABBCCDDEE;
        send_block(d, 6'd5, 4'b0100, 1'b1);
        repeat (3) @(posedge clk); #1;

        // Empty block is consumed with no output
        send_block(rnd_blk(), 6'd0, 4'b0101, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("empty_blk_idle", {bdo_valid, blk_ready}, 2'b01);
        end
        @(posedge clk); #1;

        // 16-byte block with stall pattern 1,0,0,1
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        send_block(rnd_blk(), 6'd16, 4'b1000, 1'b0);
        repeat (8) @(posedge clk); #1;

        // Verdict held back by the sink for 5 cycles
        mar_hold = 5;
        send_auth(1'b0);
        repeat (8) @(posedge clk); #1;

        // Block and verdict offered together: block first, then verdict
        d = rnd_blk();
        blk_data = d; blk_bytes = 6'd12; blk_type = 4'b1001; blk_last = 1'b1; blk_valid = 1'b1;
        auth_ok = 1'b1; auth_valid = 1'b1;
        @(negedge clk);
        check("blk_priority_ready", {blk_ready, auth_ready}, 2'b10);
        push_block(d, 6'd12, 4'b1001, 1'b1);
        @(posedge clk); #1;
        blk_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!auth_ready && k < 100);
        check("auth_after_blk", auth_ready, 1);
        push_auth(1'b1);
        @(posedge clk); #1;
        auth_valid = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Reset after the third word of an 8-word block abandons the rest
        send_block(rnd_blk(), 6'd32, 4'b0101, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("words_before_reset", exp_q.size(), 5);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", {bdo_valid, bdo, bdo_type, bdo_valid_bytes, end_of_block, msg_auth, msg_auth_valid}, 0);
        check("post_reset_idle", blk_ready, 1);
        @(posedge clk); #1;
        send_block(rnd_blk(), 6'd32, 4'b0101, 1'b1);
        repeat (10) @(posedge clk); #1;

        // Random traffic including oversize byte counts and back-pressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) send_auth(1'($urandom));
            else send_block(rnd_blk(), 6'($urandom_range(0, 40)), 4'($urandom), 1'($urandom));
        end
        k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        check("drain_scoreboard", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
